serial_add: RTL and testbench

Parametrised multi-cycle adder, successor to the single-bit full adder. It adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle LSB-first through one DIGIT-bit full-adder slice and a registered carry. It sits between operand producers and result consumers with valid/ready handshakes on both sides. It trades latency for area where a full-width ripple adder is too large.

---
 rtl/serial_add.sv | 140 ++++++++++++++
 tb/tb_serial_add.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_add.sv
// Digit-serial adder: WIDTH-bit A+B+Cin in WIDTH/DIGIT cycles, LSB digit first, valid/ready on both sides.
// Optional signed-overflow output V is built when SERIAL_ADD_OVF_EN is defined.
module serial_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             V,
`endif
  output logic [1:0]       state_o
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N < 1) ? 1 : $clog2(N + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready/out_valid are pure state decodes and never depend on inputs.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [DIGIT:0]     dsum;
  logic [WIDTH-1:0]   sum_shift;
`ifdef SERIAL_ADD_OVF_EN
  logic               v_q, v_d;
`endif

  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

  // New digit enters at the top; after N digits the LSB digit has reached bit 0.
  generate
    if (DIGIT < WIDTH) begin : g_shift
      assign sum_shift = {dsum[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign sum_shift = dsum[DIGIT-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    v_d     = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_shift;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
          s_d     = sum_shift;
          cout_d  = dsum[DIGIT];
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          v_d     = dsum[DIGIT] ^ (a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign state_o   = state_q;
`ifdef SERIAL_ADD_OVF_EN
  assign V         = v_q;
`endif

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: 8-bit DIGIT=1 instance plus 16-bit instances with DIGIT 1/4/16.
module tb_serial_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       iv8, ir8, ov8, or8, c8i, c8o;
  logic [7:0] a8, b8, s8;
  logic [1:0] st8;
  logic        iv16, or16, c16i;
  logic [15:0] a16, b16;
  logic        ir1, ov1, co1, ir4, ov4, co4, ir16, ov16, co16;
  logic [15:0] s1, s4, s16;
  logic [1:0]  st1, st4, st16;
`ifdef SERIAL_ADD_OVF_EN
  logic v8, v1, v4, v16;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] last_s = 8'h00;

  serial_add #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .Cin(c8i),
    .out_valid(ov8), .out_ready(or8), .S(s8), .Cout(c8o),
`ifdef SERIAL_ADD_OVF_EN
    .V(v8),
`endif
    .state_o(st8));

  serial_add #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir1), .A(a16), .B(b16), .Cin(c16i),
    .out_valid(ov1), .out_ready(or16), .S(s1), .Cout(co1),
`ifdef SERIAL_ADD_OVF_EN
    .V(v1),
`endif
    .state_o(st1));

  serial_add #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir4), .A(a16), .B(b16), .Cin(c16i),
    .out_valid(ov4), .out_ready(or16), .S(s4), .Cout(co4),
`ifdef SERIAL_ADD_OVF_EN
    .V(v4),
`endif
    .state_o(st4));

  serial_add #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16), .Cin(c16i),
    .out_valid(ov16), .out_ready(or16), .S(s16), .Cout(co16),
`ifdef SERIAL_ADD_OVF_EN
    .V(v16),
`endif
    .state_o(st16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input logic ev, input int hold);
    iv8 = 1'b1; a8 = a; b8 = b; c8i = c;
    step();
    iv8 = 1'b0;
    chk("accept_in_ready", {31'd0, ir8}, 32'd0);
    for (int k = 1; k < 8; k++) step();
    chk("run_out_valid", {31'd0, ov8}, 32'd0);
    chk("run_s_hold", {24'd0, s8}, {24'd0, last_s});
    step();
    chk("done_out_valid", {31'd0, ov8}, 32'd1);
    chk("done_s", {24'd0, s8}, {24'd0, es});
    chk("done_cout", {31'd0, c8o}, {31'd0, ec});
`ifdef SERIAL_ADD_OVF_EN
    chk("done_v", {31'd0, v8}, {31'd0, ev});
`endif
    for (int k = 0; k < hold; k++) begin
      iv8 = 1'b1; a8 = 8'hA5 + 8'(k); b8 = 8'h11;
      step();
      chk("hold_out_valid", {31'd0, ov8}, 32'd1);
      chk("hold_in_ready", {31'd0, ir8}, 32'd0);
      chk("hold_s", {24'd0, s8}, {24'd0, es});
      chk("hold_cout", {31'd0, c8o}, {31'd0, ec});
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    chk("handshake_in_ready", {31'd0, ir8}, 32'd0);
    step();
    or8 = 1'b0;
    chk("idle_in_ready", {31'd0, ir8}, 32'd1);
    chk("idle_out_valid", {31'd0, ov8}, 32'd0);
    chk("idle_s_hold", {24'd0, s8}, {24'd0, es});
    last_s = es;
  endtask

  task automatic add16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec);
    iv16 = 1'b1; a16 = a; b16 = b; c16i = c;
    step();
    iv16 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("lat_d1", {31'd0, ov1}, (k >= 16) ? 32'd1 : 32'd0);
      chk("lat_d4", {31'd0, ov4}, (k >= 4) ? 32'd1 : 32'd0);
      chk("lat_d16", {31'd0, ov16}, 32'd1);
      if (k == 16) chk("sum_d1", {15'd0, co1, s1}, {15'd0, ec, es});
      if (k == 4)  chk("sum_d4", {15'd0, co4, s4}, {15'd0, ec, es});
      if (k == 1)  chk("sum_d16", {15'd0, co16, s16}, {15'd0, ec, es});
    end
    or16 = 1'b1;
    step();
    or16 = 1'b0;
    chk("idle16_in_ready", {29'd0, ir1, ir4, ir16}, 32'd7);
  endtask

  initial begin
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; c8i = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; c16i = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, ir8}, 32'd1);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_s_cout", {23'd0, c8o, s8}, 32'd0);
    chk("rst_state", {30'd0, st8}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_v", {31'd0, v8}, 32'd0);
`endif
    #4 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("post_rst_idle", {21'd0, ir8, ov8, c8o, s8}, 32'h400);
    end

    add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    add8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    add8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);
    add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    add8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 5);

    // Abort an add in the middle of RUN.
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8i = 1'b0;
    step();
    iv8 = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, ir8}, 32'd1);
    chk("abort_out_valid", {31'd0, ov8}, 32'd0);
    chk("abort_s_cout", {23'd0, c8o, s8}, 32'd0);
    chk("abort_state", {30'd0, st8}, 32'd0);
    #2 rst_n = 1'b1;
    last_s = 8'h00;
    step();
    add8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    add16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    add16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    add16(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    add16(16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0);
    add16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    add16(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
